// File: rtl/axi4l_timer_pkg.sv
// Shared definitions for the AXI4-Lite RISC-V machine timer: register offsets,
// the CTRL register layout, AXI response codes and a byte-strobe merge helper.
package axi4l_timer_pkg;

    localparam logic [11:0] OFS_MTIME_LO    = 12'h000;
    localparam logic [11:0] OFS_MTIME_HI    = 12'h004;
    localparam logic [11:0] OFS_MTIMECMP_LO = 12'h008;
    localparam logic [11:0] OFS_MTIMECMP_HI = 12'h00C;
    localparam logic [11:0] OFS_CTRL        = 12'h010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [7:0]  rsvd1;
        logic [15:0] div;
        logic [6:0]  rsvd0;
        logic        en;
    } ctrl_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic ofs_valid(input logic [11:0] ofs);
        return (ofs == OFS_MTIME_LO) || (ofs == OFS_MTIME_HI) ||
               (ofs == OFS_MTIMECMP_LO) || (ofs == OFS_MTIMECMP_HI) ||
               (ofs == OFS_CTRL);
    endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle (32-bit address and data by default) with slave and master views.
interface axi4l_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input logic aclk,
    input logic aresetn
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        input  aclk, aresetn,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_timer_mtimer_core.sv
// Machine-timer datapath: prescaler, 64-bit mtime/mtimecmp with byte-strobed
// writes, CTRL register and the registered level interrupt.
module mtimer_core
    import axi4l_timer_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd99,
    parameter logic        EN_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_mtime_lo,
    input  logic        wr_mtime_hi,
    input  logic        wr_cmp_lo,
    input  logic        wr_cmp_hi,
    input  logic        wr_ctrl,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output ctrl_t       ctrl,
    output logic        irq
);
    logic [15:0] pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        irq_q, irq_d;
    logic        tick;

    always_comb begin
        tick      = ctrl_q.en && (pcnt_q == ctrl_q.div);
        mtime_inc = mtime_q + {63'd0, tick};
        pcnt_d    = pcnt_q;
        if (ctrl_q.en) pcnt_d = tick ? '0 : pcnt_q + 16'd1;

        // Software bytes override the incremented value; the full-width add keeps any carry.
        mtime_d = mtime_inc;
        if (wr_mtime_lo) mtime_d[31:0]  = apply_strb(mtime_inc[31:0], wdata, wstrb);
        if (wr_mtime_hi) mtime_d[63:32] = apply_strb(mtime_inc[63:32], wdata, wstrb);

        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) mtimecmp_d[31:0]  = apply_strb(mtimecmp_q[31:0], wdata, wstrb);
        if (wr_cmp_hi) mtimecmp_d[63:32] = apply_strb(mtimecmp_q[63:32], wdata, wstrb);

        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            if (wstrb[0]) ctrl_d.en        = wdata[0];
            if (wstrb[1]) ctrl_d.div[7:0]  = wdata[15:8];
            if (wstrb[2]) ctrl_d.div[15:8] = wdata[23:16];
            pcnt_d = '0;
        end

        irq_d = ctrl_q.en && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '{rsvd1: '0, div: DIV_RESET, rsvd0: '0, en: EN_RESET};
            irq_q      <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;
    assign ctrl     = ctrl_q;
    assign irq      = irq_q;
endmodule

// File: rtl/axi4l_timer.sv
// AXI4-Lite slave wrapper for the machine timer: handshake FSMs, address decode,
// MTIME_HI snapshot register and registered read mux.
module axi4l_timer
    import axi4l_timer_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd99,
    parameter logic        EN_RESET  = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    axi4l_if.slave axi,
    output logic   irq_timer
);
    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    wstate_e     wstate_q, wstate_d;
    rstate_e     rstate_q, rstate_d;
    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] shadow_hi_q, shadow_hi_d;

    logic [11:0] waddr, raddr;
    logic        wr_hs, ar_hs;
    logic [31:0] rd_val;
    logic        rd_err;
    logic [63:0] mtime, mtimecmp;
    ctrl_t       ctrl;
    logic        unused_bits;

    assign waddr = axi.awaddr[11:0];
    assign raddr = axi.araddr[11:0];
    assign wr_hs = (wstate_q == W_ACCEPT) && awready_q && axi.awvalid && axi.wvalid;
    assign ar_hs = (rstate_q == R_IDLE) && arready_q && axi.arvalid;
    assign unused_bits = ^{axi.aclk, axi.aresetn, axi.awaddr[31:12], axi.araddr[31:12]};

    mtimer_core #(
        .DIV_RESET(DIV_RESET),
        .EN_RESET (EN_RESET)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_mtime_lo(wr_hs && (waddr == OFS_MTIME_LO)),
        .wr_mtime_hi(wr_hs && (waddr == OFS_MTIME_HI)),
        .wr_cmp_lo  (wr_hs && (waddr == OFS_MTIMECMP_LO)),
        .wr_cmp_hi  (wr_hs && (waddr == OFS_MTIMECMP_HI)),
        .wr_ctrl    (wr_hs && (waddr == OFS_CTRL)),
        .wdata      (axi.wdata),
        .wstrb      (axi.wstrb),
        .mtime      (mtime),
        .mtimecmp   (mtimecmp),
        .ctrl       (ctrl),
        .irq        (irq_timer)
    );

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        unique case (raddr)
            OFS_MTIME_LO:    rd_val = mtime[31:0];
            OFS_MTIME_HI:    rd_val = shadow_hi_q;
            OFS_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            OFS_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            OFS_CTRL:        rd_val = ctrl;
            default:         rd_err = 1'b1;
        endcase
    end

    // AW and W are accepted together, one cycle after both are seen valid.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (wstate_q)
            W_IDLE: if (axi.awvalid && axi.wvalid) begin
                wstate_d  = W_ACCEPT;
                awready_d = 1'b1;
            end
            W_ACCEPT: begin
                awready_d = 1'b0;
                wstate_d  = W_IDLE;
                if (wr_hs) begin
                    wstate_d = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = ofs_valid(waddr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: if (axi.bready) begin
                wstate_d = W_IDLE;
                bvalid_d = 1'b0;
                bresp_d  = RESP_OKAY;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        shadow_hi_d = shadow_hi_q;
        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rstate_d  = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    if (raddr == OFS_MTIME_LO) shadow_hi_d = mtime[63:32];
                end
            end
            R_RESP: if (axi.rready) begin
                rstate_d  = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            shadow_hi_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            shadow_hi_q <= shadow_hi_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = awready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4l_timer.sv
// Scoreboard bench for axi4l_timer: random AXI-Lite traffic against an analytic
// timer model (mtime as a function of elapsed cycles since the last reanchoring).
module tb_axi4l_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_timer;

    always #5 clk = ~clk;

    axi4l_if axi (.aclk(clk), .aresetn(rst_n));

    axi4l_timer #(.DIV_RESET(16'd99), .EN_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .axi(axi), .irq_timer(irq_timer)
    );

    int checks = 0;
    int errors = 0;
    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: after edge m_cyc, mtime = m_base and prescaler phase = m_p0.
    logic [63:0]     m_base = '0;
    longint unsigned m_cyc = 0;
    longint unsigned m_p0 = 0;
    logic [15:0]     m_div = 16'd99;
    logic            m_en = 1'b1;
    logic [63:0]     m_cmp = '1;
    logic [31:0]     m_shadow = '0;
    bit              model_live = 0;
    bit              hold_b = 0;
    bit              hold_r = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [11:0] addr;
    } rd_exp_t;
    rd_exp_t     rd_q[$];
    logic [1:0]  b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mtime_at(input longint unsigned k);
        if (!m_en) return m_base;
        return m_base + 64'((m_p0 + (k - m_cyc)) / (64'(m_div) + 1));
    endfunction

    function automatic longint unsigned pcnt_at(input longint unsigned k);
        if (!m_en) return m_p0;
        return (m_p0 + (k - m_cyc)) % (64'(m_div) + 1);
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] v,
                                            input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (v & m);
    endfunction

    task automatic model_write(input longint unsigned h, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        logic [63:0]     inc;
        longint unsigned p;
        logic [31:0]     c;
        logic [1:0]      r;
        inc = mtime_at(h);
        p   = pcnt_at(h);
        r   = 2'b00;
        case (a)
            12'h000: begin m_base = {inc[63:32], merge32(inc[31:0], d, s)}; m_cyc = h; m_p0 = p; end
            12'h004: begin m_base = {merge32(inc[63:32], d, s), inc[31:0]}; m_cyc = h; m_p0 = p; end
            12'h008: m_cmp[31:0]  = merge32(m_cmp[31:0], d, s);
            12'h00C: m_cmp[63:32] = merge32(m_cmp[63:32], d, s);
            12'h010: begin
                c = merge32({8'h0, m_div, 7'h0, m_en}, d, s);
                m_base = inc; m_cyc = h; m_p0 = 0;
                m_div = c[23:8]; m_en = c[0];
            end
            default: r = 2'b10;
        endcase
        b_q.push_back(r);
    endtask

    task automatic model_read(input longint unsigned k, input logic [11:0] a);
        rd_exp_t     e;
        logic [63:0] t;
        t = mtime_at(k);
        e.addr = a; e.resp = 2'b00; e.data = '0;
        case (a)
            12'h000: begin e.data = t[31:0]; m_shadow = t[63:32]; end
            12'h004: e.data = m_shadow;
            12'h008: e.data = m_cmp[31:0];
            12'h00C: e.data = m_cmp[63:32];
            12'h010: e.data = {8'h0, m_div, 7'h0, m_en};
            default: e.resp = 2'b10;
        endcase
        rd_q.push_back(e);
    endtask

    task automatic start_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        axi.awaddr = {20'h0, a}; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    endtask

    task automatic finish_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!(axi.awready && axi.wready) && n < 100) begin @(negedge clk); n++; end
        if (axi.awready && axi.wready) model_write(cyc + 1, a, d, s);
        else begin
            checks++; errors++;
            $display("FAIL write_timeout: awready=%0b, required 1 within 100 cycles", axi.awready);
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        start_write(a, d, s);
        finish_write(a, d, s);
    endtask

    task automatic axi_read(input logic [11:0] a);
        int n = 0;
        @(negedge clk);
        axi.araddr = {20'h0, a}; axi.arvalid = 1'b1;
        while (!axi.arready && n < 100) begin @(negedge clk); n++; end
        if (axi.arready) model_read(cyc, a);
        else begin
            checks++; errors++;
            $display("FAIL read_timeout: arready=%0b, required 1 within 100 cycles", axi.arready);
        end
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_q.size() != 0 || b_q.size() != 0 || axi.rvalid || axi.bvalid) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d reads and %0d writes outstanding, required 0",
                     rd_q.size(), b_q.size());
        end
    endtask

    // Response monitor: pops the scoreboard on every completed R or B handshake.
    always @(negedge clk) begin
        if (rst_n && axi.rvalid && axi.rready) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: rdata=0x%0h with no read outstanding", axi.rdata);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check($sformatf("rdata@%03h", e.addr), 64'(axi.rdata), 64'(e.data));
                check($sformatf("rresp@%03h", e.addr), 64'(axi.rresp), 64'(e.resp));
            end
        end
        if (rst_n && axi.bvalid && axi.bready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_bvalid: bresp=%0d with no write outstanding", axi.bresp);
            end else begin
                logic [1:0] eb;
                eb = b_q.pop_front();
                check("bresp", 64'(axi.bresp), 64'(eb));
            end
        end
    end

    initial begin
        axi.bready = 1'b0; axi.rready = 1'b0;
        forever begin
            @(posedge clk); #2;
            axi.bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
            axi.rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // irq after edge k must equal en & (mtime >= mtimecmp) as of edge k-1.
    initial begin
        bit prev_cond = 0;
        bit irq_live = 0;
        logic [63:0] t;
        forever begin
            @(posedge clk); #1;
            if (irq_live) check("irq_timer", 64'(irq_timer), 64'(prev_cond));
            if (model_live) begin
                t = mtime_at(cyc);
                prev_cond = m_en && (t >= m_cmp);
                irq_live = 1;
            end
        end
    end

    initial begin
        logic [11:0] ofs_tab[7];
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        ofs_tab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'h014};
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.araddr = '0; axi.arvalid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_irq", 64'(irq_timer), 64'd0);
        check("reset_bvalid", 64'(axi.bvalid), 64'd0);
        check("reset_rvalid", 64'(axi.rvalid), 64'd0);
        check("reset_awready", 64'(axi.awready), 64'd0);
        check("reset_arready", 64'(axi.arready), 64'd0);
        check("reset_rdata", 64'(axi.rdata), 64'd0);
        rst_n = 1'b1;
        m_cyc = cyc;
        model_live = 1;

        axi_read(12'h010);
        axi_read(12'h008);
        axi_read(12'h000);
        drain();

        axi_write(12'h010, 32'h0000_0001, 4'hF);
        repeat (10) @(negedge clk);
        axi_read(12'h000);
        axi_read(12'h000);
        drain();

        axi_write(12'h004, 32'h0, 4'hF);
        axi_write(12'h000, 32'hFFFF_FFFE, 4'hF);
        axi_read(12'h000);
        axi_read(12'h004);
        repeat (3) @(negedge clk);
        axi_read(12'h000);
        axi_read(12'h004);
        drain();

        axi_write(12'h00C, 32'h0, 4'hF);
        axi_write(12'h008, 32'h0000_0040, 4'hF);
        axi_write(12'h004, 32'h0, 4'hF);
        axi_write(12'h000, 32'h0, 4'hF);
        repeat (80) @(negedge clk);
        check("irq_after_cmp", 64'(irq_timer), 64'd1);
        axi_write(12'h00C, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(negedge clk);
        check("irq_after_cmp_hi", 64'(irq_timer), 64'd0);
        drain();

        axi_write(12'h020, 32'h1234_5678, 4'hF);
        axi_read(12'h020);
        axi_read(12'h008);
        axi_read(12'h00C);
        axi_read(12'h010);
        drain();

        hold_b = 1;
        repeat (2) @(negedge clk);
        axi_write(12'h008, 32'hA5A5_0000, 4'hC);
        start_write(12'h008, 32'h0000_5A5A, 4'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bvalid_hold", 64'(axi.bvalid), 64'd1);
            check("awready_blocked", 64'(axi.awready), 64'd0);
        end
        hold_b = 0;
        finish_write(12'h008, 32'h0000_5A5A, 4'h3);
        drain();

        hold_r = 1;
        repeat (2) @(negedge clk);
        axi_read(12'h008);
        begin
            int n = 0;
            while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rvalid_hold", 64'(axi.rvalid), 64'd1);
            if (rd_q.size() != 0) check("rdata_stable", 64'(axi.rdata), 64'(rd_q[0].data));
        end
        hold_r = 0;
        drain();

        for (int i = 0; i < 300; i++) begin
            a = ofs_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 2) != 0) axi_read(a);
            else begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                if (a == 12'h010) begin
                    d[23:16] = 8'h00;
                    d[15:8]  = 8'($urandom_range(0, 3));
                    d[0]     = ($urandom_range(0, 3) != 0);
                end
                axi_write(a, d, s);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
